// File: rtl/keypad_scanner_if.sv
// Keypad scanner bundle: matrix strobe/sense lines plus the decoded key and entry value.
interface keypad_scanner_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [6:0] Number;

  modport master (
    input  row_in,
    output col_out, key_code, key_valid, key_held, Number
  );

  modport slave (
    output row_in,
    input  col_out, key_code, key_valid, key_held, Number
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobing, per-press debounce, hex key code
// output and a two-digit decimal entry value built from the digit keys.
module keypad_scanner #(
  parameter int SCAN_DIV         = 100000,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  keypad_scanner_if.master  kp
);

  localparam int             CW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]  DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [3:0]     DS         = 4'(DEBOUNCE_SAMPLES);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t        state_reg;
  logic [3:0]    row_meta_reg;
  logic [3:0]    rs_reg;
  logic [CW-1:0] dwell_reg;
  logic [1:0]    col_reg;
  logic [1:0]    cand_reg;
  logic [3:0]    db_cnt_reg;
  logic [3:0]    rel_cnt_reg;
  logic [3:0]    key_code_reg;
  logic          key_valid_reg;
  logic          key_held_reg;
  logic [6:0]    number_reg;

  logic          sample;
  logic [1:0]    low_row;
  logic [3:0]    detect_code;
  logic [3:0]    cand_code;
  logic [6:0]    ones_digit;
  logic [6:0]    number_next;

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'b00_00: key_lookup = 4'h1;
      4'b00_01: key_lookup = 4'h2;
      4'b00_10: key_lookup = 4'h3;
      4'b00_11: key_lookup = 4'hA;
      4'b01_00: key_lookup = 4'h4;
      4'b01_01: key_lookup = 4'h5;
      4'b01_10: key_lookup = 4'h6;
      4'b01_11: key_lookup = 4'hB;
      4'b10_00: key_lookup = 4'h7;
      4'b10_01: key_lookup = 4'h8;
      4'b10_10: key_lookup = 4'h9;
      4'b10_11: key_lookup = 4'hC;
      4'b11_00: key_lookup = 4'h0;
      4'b11_01: key_lookup = 4'hF;
      4'b11_10: key_lookup = 4'hE;
      default:  key_lookup = 4'hD;
    endcase
  endfunction

  assign sample = (dwell_reg == DWELL_LAST);

  // Lowest-index low row wins when several rows are pulled down at once.
  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rs_reg[i]) low_row = 2'(i);
    end
  end

  assign detect_code = key_lookup(low_row, col_reg);
  assign cand_code   = key_lookup(cand_reg, col_reg);

  // Keeping only the ones digit before shifting bounds the result to 99.
  always_comb begin
    ones_digit  = number_reg % 7'd10;
    number_next = number_reg;
    if (key_code_reg <= 4'd9)
      number_next = ones_digit * 7'd10 + {3'b000, key_code_reg};
    else if (key_code_reg == 4'hC)
      number_next = 7'd0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg     <= SCAN;
      row_meta_reg  <= 4'hF;
      rs_reg        <= 4'hF;
      dwell_reg     <= '0;
      col_reg       <= 2'd0;
      cand_reg      <= 2'd0;
      db_cnt_reg    <= 4'd0;
      rel_cnt_reg   <= 4'd0;
      key_code_reg  <= 4'd0;
      key_valid_reg <= 1'b0;
      key_held_reg  <= 1'b0;
      number_reg    <= 7'd0;
    end else begin
      row_meta_reg  <= kp.row_in;
      rs_reg        <= row_meta_reg;
      key_valid_reg <= 1'b0;
      dwell_reg     <= sample ? '0 : dwell_reg + 1'b1;
      if (key_valid_reg) number_reg <= number_next;

      if (sample) begin
        case (state_reg)
          SCAN: begin
            if (rs_reg == 4'hF) begin
              col_reg <= col_reg + 2'd1;
            end else begin
              cand_reg <= low_row;
              if (DS == 4'd1) begin
                key_code_reg  <= detect_code;
                key_valid_reg <= 1'b1;
                key_held_reg  <= 1'b1;
                rel_cnt_reg   <= 4'd0;
                state_reg     <= HELD;
              end else begin
                db_cnt_reg <= 4'd1;
                state_reg  <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            if (!rs_reg[cand_reg]) begin
              if (db_cnt_reg + 4'd1 == DS) begin
                key_code_reg  <= cand_code;
                key_valid_reg <= 1'b1;
                key_held_reg  <= 1'b1;
                rel_cnt_reg   <= 4'd0;
                state_reg     <= HELD;
              end else begin
                db_cnt_reg <= db_cnt_reg + 4'd1;
              end
            end else begin
              state_reg <= SCAN;
              col_reg   <= col_reg + 2'd1;
            end
          end
          HELD: begin
            if (rs_reg == 4'hF) begin
              if (rel_cnt_reg + 4'd1 == DS) begin
                state_reg    <= SCAN;
                col_reg      <= col_reg + 2'd1;
                key_held_reg <= 1'b0;
                rel_cnt_reg  <= 4'd0;
              end else begin
                rel_cnt_reg <= rel_cnt_reg + 4'd1;
              end
            end else begin
              rel_cnt_reg <= 4'd0;
            end
          end
          default: state_reg <= SCAN;
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    assign kp.col_out[gi] = (col_reg != 2'(gi));
  end

  assign kp.key_code  = key_code_reg;
  assign kp.key_valid = key_valid_reg;
  assign kp.key_held  = key_held_reg;
  assign kp.Number    = number_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model closes one row/column contact, a
// scoreboard queue holds the expected code/value of every accepted press.
module tb_keypad_scanner;

  logic clk;
  logic Reset;

  keypad_scanner_if bus();

  keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE_SAMPLES(3)) dut (
    .Clk   (clk),
    .Reset (Reset),
    .kp    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    logic [6:0] num;
  } exp_t;

  exp_t exp_q[$];

  int n_compared   = 0;
  int n_mismatched = 0;
  int valid_count  = 0;

  logic [6:0] num_model = 7'd0;

  // Keypad contact model, with a raw override for bounce stimulus.
  logic       key_down   = 1'b0;
  int         key_row    = 0;
  int         key_col    = 0;
  logic       force_en   = 1'b0;
  logic [3:0] force_rows = 4'hF;
  logic [3:0] row_model;

  always_comb begin
    row_model = 4'hF;
    if (key_down && bus.col_out[key_col] == 1'b0) row_model[key_row] = 1'b0;
  end
  assign bus.row_in = force_en ? force_rows : row_model;

  // Scoreboard monitor: every key_valid pulse pops one expectation.
  logic       prev_valid  = 1'b0;
  logic       num_pending = 1'b0;
  logic [6:0] num_exp     = 7'd0;

  always @(negedge clk) begin
    if (Reset) begin
      prev_valid  = 1'b0;
      num_pending = 1'b0;
    end else begin
      if (num_pending) begin
        n_compared++;
        if (bus.Number !== num_exp) begin
          n_mismatched++;
          $display("FAIL number_after_valid: got %0d expected %0d", bus.Number, num_exp);
        end
        num_pending = 1'b0;
      end
      if (bus.key_valid === 1'b1) begin
        valid_count++;
        n_compared++;
        if (prev_valid) begin
          n_mismatched++;
          $display("FAIL valid_back_to_back: key_valid high two cycles in a row");
        end
        if (exp_q.size() == 0) begin
          n_mismatched++;
          $display("FAIL unexpected_valid: key_valid with code %h, none expected", bus.key_code);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          n_compared++;
          if (bus.key_code !== e.code || bus.key_held !== 1'b1) begin
            n_mismatched++;
            $display("FAIL key_code: got %h held %b expected %h held 1",
                     bus.key_code, bus.key_held, e.code);
          end
          $display("press accepted: code=%h expect_number=%0d", bus.key_code, e.num);
          num_exp     = e.num;
          num_pending = 1'b1;
        end
      end
      prev_valid = bus.key_valid;
    end
  end

  task automatic wait_col(input logic [3:0] target, output bit ok);
    int n;
    n  = 0;
    ok = 1'b0;
    @(negedge clk);
    while (bus.col_out !== target && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.col_out === target);
  endtask

  task automatic press_key(input int r, input int c, input logic [3:0] code, input int hold);
    exp_t e;
    int   n;
    if (code <= 4'd9) num_model = (num_model % 7'd10) * 7'd10 + {3'b000, code};
    else if (code == 4'hC) num_model = 7'd0;
    e.code = code;
    e.num  = num_model;
    exp_q.push_back(e);
    key_row  = r;
    key_col  = c;
    key_down = 1'b1;
    n = 0;
    @(negedge clk);
    while (bus.key_held !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_compared++;
    if (bus.key_held !== 1'b1) begin
      n_mismatched++;
      $display("FAIL press_timeout: key %h never held", code);
    end
    repeat (hold) @(posedge clk);
  endtask

  task automatic release_key();
    int n;
    key_down = 1'b0;
    n = 0;
    @(negedge clk);
    while (bus.key_held !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_compared++;
    if (bus.key_held !== 1'b0) begin
      n_mismatched++;
      $display("FAIL release_timeout: key_held stuck at %b", bus.key_held);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    Reset = 1'b1;
    repeat (2) @(negedge clk);
    Reset     = 1'b0;
    num_model = 7'd0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    @(negedge clk);
    Reset = 1'b0;
    repeat (13) @(posedge clk);
    #2 Reset = 1'b1;
    #1;
    n_compared++;
    if (bus.col_out !== 4'b1110 || bus.key_code !== 4'h0 || bus.key_valid !== 1'b0 ||
        bus.key_held !== 1'b0 || bus.Number !== 7'd0) begin
      n_mismatched++;
      $display("FAIL reset_values: col=%b code=%h valid=%b held=%b num=%0d expected 1110/0/0/0/0",
               bus.col_out, bus.key_code, bus.key_valid, bus.key_held, bus.Number);
    end
    @(negedge clk);
    Reset = 1'b0;
    repeat (4) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << (i % 4));
      n_compared++;
      if (bus.col_out !== exp_col) begin
        n_mismatched++;
        $display("FAIL col_sequence[%0d]: got %b expected %b", i, bus.col_out, exp_col);
      end
      $display("scan step %0d: col_out=%b", i, bus.col_out);
      repeat (8) @(posedge clk);
    end
  endtask

  task automatic test_single_press();
    int base;
    base = valid_count;
    press_key(1, 1, 4'h5, 40);
    n_compared++;
    if (bus.key_held !== 1'b1 || valid_count != base + 1) begin
      n_mismatched++;
      $display("FAIL single_press_hold: held=%b pulses=%0d expected held 1 pulses 1",
               bus.key_held, valid_count - base);
    end
    release_key();
    n_compared++;
    if (bus.col_out !== 4'b1011) begin
      n_mismatched++;
      $display("FAIL scan_resume: col_out %b expected 1011", bus.col_out);
    end
    $display("single press done: number=%0d", bus.Number);
  endtask

  task automatic test_bounce();
    bit ok;
    int base;
    base       = valid_count;
    force_rows = 4'hF;
    force_en   = 1'b1;
    wait_col(4'b0111, ok);
    if (ok) wait_col(4'b1110, ok);
    n_compared++;
    if (!ok) begin
      n_mismatched++;
      $display("FAIL bounce_sync: col_out %b never reached column 0", bus.col_out);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    force_rows = 4'b1011;
    @(negedge clk);
    force_rows = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_compared++;
    if (bus.col_out !== 4'b1110) begin
      n_mismatched++;
      $display("FAIL bounce_freeze: col_out %b expected 1110", bus.col_out);
    end
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_compared++;
    if (bus.col_out !== 4'b1101 || valid_count != base || bus.Number !== 7'd5) begin
      n_mismatched++;
      $display("FAIL bounce_reject: col=%b pulses=%0d num=%0d expected 1101/0/5",
               bus.col_out, valid_count - base, bus.Number);
    end
    $display("bounce rejected: col_out=%b", bus.col_out);
    force_en = 1'b0;
  endtask

  task automatic test_digit_entry();
    int         rows  [3] = '{1, 0, 2};
    int         cols  [3] = '{0, 1, 0};
    logic [3:0] codes [3] = '{4'h4, 4'h2, 4'h7};
    logic [6:0] nums  [3] = '{7'd4, 7'd42, 7'd27};
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      press_key(rows[i], cols[i], codes[i], 5);
      release_key();
      n_compared++;
      if (bus.Number !== nums[i]) begin
        n_mismatched++;
        $display("FAIL digit_entry[%0d]: number %0d expected %0d", i, bus.Number, nums[i]);
      end
      $display("digit %h entered: number=%0d", codes[i], bus.Number);
    end
  endtask

  task automatic test_clear_letters();
    press_key(2, 3, 4'hC, 5);
    release_key();
    n_compared++;
    if (bus.key_code !== 4'hC || bus.Number !== 7'd0) begin
      n_mismatched++;
      $display("FAIL clear_key: code %h num %0d expected C/0", bus.key_code, bus.Number);
    end
    press_key(0, 3, 4'hA, 5);
    release_key();
    n_compared++;
    if (bus.key_code !== 4'hA || bus.Number !== 7'd0) begin
      n_mismatched++;
      $display("FAIL letter_key: code %h num %0d expected A/0", bus.key_code, bus.Number);
    end
    $display("clear/letter done: code=%h number=%0d", bus.key_code, bus.Number);
  endtask

  task automatic test_reset_mid_debounce();
    bit   ok;
    int   base;
    int   first;
    int   pulses;
    exp_t e;
    base = valid_count;
    wait_col(4'b1110, ok);
    key_row  = 2;
    key_col  = 1;
    key_down = 1'b1;
    if (ok) wait_col(4'b1101, ok);
    n_compared++;
    if (!ok) begin
      n_mismatched++;
      $display("FAIL mid_debounce_sync: col_out %b never reached column 1", bus.col_out);
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    Reset = 1'b1;
    repeat (2) @(negedge clk);
    Reset     = 1'b0;
    num_model = 7'd0;
    n_compared++;
    if (valid_count != base) begin
      n_mismatched++;
      $display("FAIL mid_debounce_discard: %0d pulses expected 0", valid_count - base);
    end
    e.code = 4'h8;
    e.num  = 7'd8;
    exp_q.push_back(e);
    first  = -1;
    pulses = 0;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.key_valid === 1'b1) begin
        pulses++;
        if (first < 0) first = n;
      end
    end
    n_compared++;
    if (pulses != 1 || first != 32) begin
      n_mismatched++;
      $display("FAIL redetect_after_reset: pulses=%0d at cycle %0d expected 1 at 32", pulses, first);
    end
    $display("redetect after reset: pulses=%0d cycle=%0d", pulses, first);
    release_key();
  endtask

  initial begin
    Reset = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    test_single_press();
    test_bounce();
    test_digit_entry();
    test_clear_letters();
    test_reset_mid_debounce();
    repeat (4) @(negedge clk);
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL scoreboard_drain: %0d expected presses never seen", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side counterpart to the multiplexed seven-segment display driver: scans a 4x4 matrix keypad (Pmod KYPD style) by strobing columns and reading rows, debounces each press, and emits one hex key code per press. It also holds a two-digit decimal entry value (0..99) built from the digit keys. That value feeds the display driver's 7-bit `Number` input, letting a user type a value and see it on the board.

## Interface
- `SCAN_DIV`, default 100000: clock cycles each column is driven (1 ms at 100 MHz). Minimum 4.
- `DEBOUNCE_SAMPLES`, default 4: consecutive identical samples required to accept a press or a release. Range 1..15.
- `Clk` input 1: system clock, one clock domain.
- `Reset` input 1: asynchronous, active-high reset.
- `row_in` input 4: keypad rows, active-low, externally pulled up, asynchronous to `Clk`.
- `col_out` output 4: keypad column strobes, active-low, exactly one bit low at all times.
- `key_code` output 4: hex code of the last accepted key; holds its value between presses.
- `key_valid` output 1: one-cycle pulse when a press is accepted.
- `key_held` output 1: high while an accepted key remains pressed (until its release is debounced).
- `Number` output 7: decimal entry value, always 0..99.

## Operation
- `row_in` passes through a 2-flop synchronizer. All decisions use the synchronized rows (`rs`).
- Dwell counter counts 0..SCAN_DIV-1 per column. The sample point is the cycle where the count equals SCAN_DIV-1.
- `col_out` = ~(1 << col). Column index `col` runs 0..3 and wraps from 3 to 0.
- Key map, as (row, col) -> code:
  - Row 0: 1, 2, 3, A
  - Row 1: 4, 5, 6, B
  - Row 2: 7, 8, 9, C
  - Row 3: 0, F, E, D
- State machine:
  - **SCAN**: at the sample point:
    - If `rs` == 4'hF, advance `col`.
    - Otherwise latch the lowest-index low row as the candidate, set the debounce count to 1, and go to DEBOUNCE. `col` does not advance.
  - **DEBOUNCE**: `col` is frozen. At each sample point:
    - If the candidate row is still low, increment the count. When the count reaches DEBOUNCE_SAMPLES, register `key_code` and assert `key_valid`, then go to HELD.
    - If the candidate row is high, go to SCAN and advance `col`. No output is produced.
  - **HELD**: `col` is frozen and `key_held` = 1. At each sample point:
    - If `rs` == 4'hF, increment the release count. Any low row clears the release count to 0.
    - When the release count reaches DEBOUNCE_SAMPLES, go to SCAN, advance `col`, and drop `key_held`.
  - With DEBOUNCE_SAMPLES = 1, the first detecting sample is accepted directly from SCAN.
- Other keys pressed while in HELD are ignored. A key is never repeated while held.
- Number update, applied on the edge where `key_valid` = 1:
  - Code 0..9: `Number` <= (`Number` % 10) * 10 + code.
  - Code 0xC: `Number` <= 0.
  - Codes A, B, D, E, F: no change.
- Arithmetic is 7-bit unsigned. The result can never exceed 99.

## Timing
- Reset values: `col_out` = 4'b1110, `key_code` = 0, `key_valid` = 0, `key_held` = 0, `Number` = 0. State is SCAN and all counters are 0.
- Reset asserted mid-operation clears everything immediately and asynchronously. A debounce in progress is discarded and no `key_valid` is produced. If a key is still held after reset deasserts, it is detected again as a new press.
- Input latency: a `row_in` change reaches `rs` after 2 clock edges.
- Column settling: the sample point is SCAN_DIV-1 cycles after the column switches, which requires SCAN_DIV ≥ 4.
- Press acceptance:
  - `key_valid` and `key_code` appear the cycle after the DEBOUNCE_SAMPLES-th confirming sample point.
  - `key_held` rises in that same cycle.
  - `Number` shows the new value one cycle later.
  - Acceptance takes (DEBOUNCE_SAMPLES-1) × SCAN_DIV cycles after first detection.
- `key_held` falls the cycle after the DEBOUNCE_SAMPLES-th all-high sample point.
- `key_valid` is never high for two consecutive cycles. Two presses produce at least 2 × DEBOUNCE_SAMPLES sample periods between their pulses.

## Test plan
All scenarios run with SCAN_DIV = 8 and DEBOUNCE_SAMPLES = 3.
- **Reset values:** assert `Reset` at an arbitrary time → all outputs at their reset values within the same cycle. `col_out` then cycles 1110, 1101, 1011, 0111, 1110 every 8 clocks while `row_in` = 4'hF.
- **Single press:** drive row 1 low only while `col_out` = 4'b1101 (key 5) and hold it → exactly one `key_valid` pulse with `key_code` = 5, then `Number` = 5. `key_held` stays 1 until row 1 is released for 3 samples, after which scanning resumes.
- **Bounce rejection:** row 2 low at a single sample point on column 0, then high → no `key_valid`, `Number` unchanged, and `col_out` advances to 4'b1101.
- **Digit entry:** press and release 4, then 2, then 7 → `Number` goes 4, then 42, then 27. Three `key_valid` pulses with codes 4, 2, 7.
- **Clear and letter keys:** with `Number` = 27, press C (row 2, column 3) → `key_code` = 0xC and `Number` = 0. Then press A → `key_code` = 0xA and `Number` stays 0.
- **Reset mid-debounce:** assert `Reset` after 2 confirming samples → no `key_valid`. With the key still held after `Reset` deasserts, exactly one `key_valid` pulse follows, 3 samples after the column returns to that key.
